// File: rtl/serial_pattern_pkg.sv
// Shared types and width helpers for the serial pattern transmitter.
package serial_pattern_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SHIFT,
      TX_DONE
   } tx_state_t;

   // Width of a counter that must hold values up to n, never less than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period clock-enable: tick marks the last clk cycle of each DIV-cycle bit.
module bit_tick_gen
   import serial_pattern_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned   CW   = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_pattern_tx.sv
// Latches a WIDTH-bit pattern and shifts it out MSB-first on x, one bit per DIV clocks.
module serial_pattern_tx
   import serial_pattern_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] data,
   output logic             x,
   output logic             x_valid,
   output logic             bit_stb,
   output logic             busy,
   output logic             done
);

   localparam int unsigned   BW       = cnt_width(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   tx_state_t        state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic             x_q, x_d, xv_q, xv_d, stb_q, stb_d, busy_q, busy_d, done_q, done_d;
   logic             div_clr, tick;

   bit_tick_gen #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .reset(reset),
      .clr  (div_clr),
      .en   (state_q == TX_SHIFT),
      .tick (tick)
   );

   // Outputs are computed as next-state values so every output is a flop.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bcnt_d  = bcnt_q;
      div_clr = 1'b0;
      x_d     = 1'b0;
      xv_d    = 1'b0;
      stb_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            if (start) begin
               state_d = TX_SHIFT;
               sr_d    = data;
               bcnt_d  = '0;
               div_clr = 1'b1;
               x_d     = data[WIDTH-1];
               xv_d    = 1'b1;
               stb_d   = 1'b1;
               busy_d  = 1'b1;
            end
         end
         TX_SHIFT: begin
            if (abort) begin
               state_d = TX_IDLE;
               sr_d    = '0;
               bcnt_d  = '0;
               div_clr = 1'b1;
            end else if (tick) begin
               sr_d = sr_q << 1;
               if (bcnt_q == LAST_BIT) begin
                  state_d = TX_DONE;
                  bcnt_d  = '0;
                  done_d  = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  bcnt_d = bcnt_q + BW'(1);
                  x_d    = sr_q[WIDTH-2];
                  xv_d   = 1'b1;
                  stb_d  = 1'b1;
                  busy_d = 1'b1;
               end
            end else begin
               x_d    = sr_q[WIDTH-1];
               xv_d   = 1'b1;
               busy_d = 1'b1;
            end
         end
         TX_DONE: begin
            state_d = TX_IDLE;
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= TX_IDLE;
         sr_q    <= '0;
         bcnt_q  <= '0;
         x_q     <= 1'b0;
         xv_q    <= 1'b0;
         stb_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         bcnt_q  <= bcnt_d;
         x_q     <= x_d;
         xv_q    <= xv_d;
         stb_q   <= stb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign x       = x_q;
   assign x_valid = xv_q;
   assign bit_stb = stb_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench: expected bits are queued at start and popped on each bit_stb.
module tb_serial_pattern_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, abort;
   logic [7:0] data;
   logic       x, x_valid, bit_stb, busy, done;

   logic       start2, abort2;
   logic [3:0] data2;
   logic       x2, xv2, stb2, busy2, done2;

   int unsigned tests = 0;
   int unsigned fails = 0;

   logic exp_q[$];
   logic exp2_q[$];

   always #5 clk = ~clk;

   serial_pattern_tx #(.WIDTH(8), .DIV(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .abort  (abort),
      .data   (data),
      .x      (x),
      .x_valid(x_valid),
      .bit_stb(bit_stb),
      .busy   (busy),
      .done   (done)
   );

   serial_pattern_tx #(.WIDTH(4), .DIV(1)) dut2 (
      .clk    (clk),
      .reset  (reset),
      .start  (start2),
      .abort  (abort2),
      .data   (data2),
      .x      (x2),
      .x_valid(xv2),
      .bit_stb(stb2),
      .busy   (busy2),
      .done   (done2)
   );

   task automatic test_reset();
      reset = 1'b0; start = 1'b1; start2 = 1'b1; abort = 1'b0; abort2 = 1'b0;
      data = 8'hA5; data2 = 4'hA;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests++;
         if ({x, x_valid, bit_stb, busy, done, x2, xv2, stb2, busy2, done2} !== 10'b0) begin
            fails++;
            $display("FAIL reset c=%0d outputs got %b%b%b%b%b_%b%b%b%b%b exp all 0", c,
                     x, x_valid, bit_stb, busy, done, x2, xv2, stb2, busy2, done2);
         end
      end
      start = 1'b0; start2 = 1'b0; reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] pat;
      logic       eb;
      pat = 8'hB4;
      data = pat; start = 1'b1;
      for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 34; c++) begin
         if (c > 0) @(negedge clk);
         tests++;
         if (c < 32) begin
            if ({x_valid, busy, done, bit_stb} !== {3'b110, (c % 4 == 0)}) begin
               fails++;
               $display("FAIL basic_flags c=%0d got %b exp %b", c,
                        {x_valid, busy, done, bit_stb}, {3'b110, (c % 4 == 0)});
            end
            if (bit_stb) begin
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL basic_sb c=%0d got strobe exp empty queue", c);
               end else begin
                  eb = exp_q.pop_front();
                  if (x !== eb) begin
                     fails++;
                     $display("FAIL basic_bit c=%0d got %b exp %b", c, x, eb);
                  end
               end
            end
         end else if (c == 32) begin
            if ({x, x_valid, bit_stb, busy, done} !== 5'b00011) begin
               fails++;
               $display("FAIL basic_done c=32 got %b exp 00011", {x, x_valid, bit_stb, busy, done});
            end
         end else begin
            if ({x, x_valid, bit_stb, busy, done} !== 5'b00000) begin
               fails++;
               $display("FAIL basic_idle c=33 got %b exp 00000", {x, x_valid, bit_stb, busy, done});
            end
         end
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL basic_left got %0d exp 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_div1();
      logic [3:0] pat;
      logic       eb;
      pat = 4'b1001;
      data2 = pat; start2 = 1'b1;
      for (int i = 3; i >= 0; i--) exp2_q.push_back(pat[i]);
      @(negedge clk);
      start2 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         tests++;
         if (c < 4) begin
            if ({xv2, stb2, busy2, done2} !== 4'b1110) begin
               fails++;
               $display("FAIL div1_flags c=%0d got %b exp 1110", c, {xv2, stb2, busy2, done2});
            end
            if (exp2_q.size() == 0) begin
               fails++;
               $display("FAIL div1_sb c=%0d got strobe exp empty queue", c);
            end else begin
               eb = exp2_q.pop_front();
               if (x2 !== eb) begin
                  fails++;
                  $display("FAIL div1_bit c=%0d got %b exp %b", c, x2, eb);
               end
            end
         end else if (c == 4) begin
            if ({x2, xv2, stb2, busy2, done2} !== 5'b00011) begin
               fails++;
               $display("FAIL div1_done c=4 got %b exp 00011", {x2, xv2, stb2, busy2, done2});
            end
         end else begin
            if ({x2, xv2, stb2, busy2, done2} !== 5'b00000) begin
               fails++;
               $display("FAIL div1_idle c=5 got %b exp 00000", {x2, xv2, stb2, busy2, done2});
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_busy, exp_done, exp_stb;
      data = 8'hFF; start = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 67; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 34) start = 1'b0;
         exp_done = (c == 32) || (c == 66);
         exp_busy = (c != 33);
         exp_stb  = (c < 32 && c % 4 == 0) || (c >= 34 && c < 66 && (c - 34) % 4 == 0);
         tests++;
         if ({busy, done, bit_stb, x} !== {exp_busy, exp_done, exp_stb, exp_busy & ~exp_done}) begin
            fails++;
            $display("FAIL b2b c=%0d got %b exp %b", c, {busy, done, bit_stb, x},
                     {exp_busy, exp_done, exp_stb, exp_busy & ~exp_done});
         end
      end
      @(negedge clk);
   endtask

   task automatic test_abort();
      logic [7:0] pat;
      logic       eb;
      logic       seen_done;
      int         c;
      pat = 8'hB4;
      data = pat; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (c = 0; c < 15; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 12) abort = 1'b1;
         if (c == 13) begin
            abort = 1'b0;
            tests++;
            if ({x, x_valid, busy, bit_stb} !== 4'b0000) begin
               fails++;
               $display("FAIL abort_idle c=13 got %b exp 0000", {x, x_valid, busy, bit_stb});
            end
         end
         if (c == 14) begin
            start = 1'b1;
            for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
         end
         tests++;
         if (done !== 1'b0) begin
            fails++;
            $display("FAIL abort_done c=%0d got %b exp 0", c, done);
         end
      end
      seen_done = 1'b0;
      for (c = 15; c < 60 && !seen_done; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 15) begin
            tests++;
            if ({bit_stb, busy} !== 2'b11) begin
               fails++;
               $display("FAIL abort_restart c=15 got %b exp 11", {bit_stb, busy});
            end
         end
         if (bit_stb) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL abort_sb c=%0d got strobe exp empty queue", c);
            end else begin
               eb = exp_q.pop_front();
               if (x !== eb) begin
                  fails++;
                  $display("FAIL abort_bit c=%0d got %b exp %b", c, x, eb);
               end
            end
         end
         if (done) begin
            seen_done = 1'b1;
            tests++;
            if (c != 47) begin
               fails++;
               $display("FAIL abort_done_time got %0d exp 47", c);
            end
         end
      end
      tests++;
      if (!seen_done || exp_q.size() != 0) begin
         fails++;
         $display("FAIL abort_finish got done=%b left=%0d exp done=1 left=0", seen_done, exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic [7:0] pat;
      logic       eb;
      int         done_at;
      data = 8'hB4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      tests++;
      if ({x_valid, busy} !== 2'b00 || x !== 1'b0) begin
         fails++;
         $display("FAIL async_reset got x=%b xv=%b busy=%b exp 000", x, x_valid, busy);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL async_done got %b exp 0", done);
      end
      reset = 1'b1;
      @(negedge clk);
      pat = 8'h01;
      data = pat; start = 1'b1;
      for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
      done_at = -1;
      for (int c = 0; c < 40 && done_at < 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (bit_stb) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL async_sb c=%0d got strobe exp empty queue", c);
            end else begin
               eb = exp_q.pop_front();
               if (x !== eb) begin
                  fails++;
                  $display("FAIL async_bit c=%0d got %b exp %b", c, x, eb);
               end
            end
         end
         if (done) done_at = c;
      end
      tests++;
      if (done_at != 32 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL async_finish got done_at=%0d left=%0d exp 32 0", done_at, exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_data_toggle();
      logic [7:0] pat;
      logic       eb;
      int         done_at;
      pat = 8'h5A;
      data = pat; start = 1'b1;
      for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
      done_at = -1;
      for (int c = 0; c < 40 && done_at < 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         data  = 8'($urandom);
         if (bit_stb) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL toggle_sb c=%0d got strobe exp empty queue", c);
            end else begin
               eb = exp_q.pop_front();
               if (x !== eb) begin
                  fails++;
                  $display("FAIL toggle_bit c=%0d got %b exp %b", c, x, eb);
               end
            end
         end
         if (done) done_at = c;
      end
      tests++;
      if (done_at != 32 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL toggle_finish got done_at=%0d left=%0d exp 32 0", done_at, exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_div1();
      test_back_to_back();
      test_abort();
      test_async_reset();
      test_data_toggle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
